// File: rtl/bus_pkg.sv
// Shared datapath-bus definitions: default width, source slot indices, and
// the arbitration mode enum used by the bus arbiter and its consumers.
package bus_pkg;

  localparam int BUS_WIDTH = 16;

  localparam int SRC_PC     = 0;
  localparam int SRC_MDR    = 1;
  localparam int SRC_ALU    = 2;
  localparam int SRC_MARMUX = 3;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

endpackage : bus_pkg

// File: rtl/bus_arb_mux_if.sv
// Datapath bus bundle: source requests/data toward the arbiter, grants and the
// registered bus value back toward sources and consumers.
interface bus_arb_mux_if
  import bus_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH,
  parameter int N_SRC = 4
) ();

  localparam int OW = $clog2(N_SRC);

  logic [N_SRC-1:0]       src_req;
  logic [N_SRC*WIDTH-1:0] src_data;
  logic                   hold;
  logic                   clear_sticky;
  logic [N_SRC-1:0]       src_gnt;
  logic [WIDTH-1:0]       bus_out;
  logic                   bus_valid;
  logic [OW-1:0]          bus_owner;
  logic                   conflict;
  logic                   conflict_sticky;

  // Sources and bus consumers.
  modport master (
    output src_req, src_data, hold, clear_sticky,
    input  src_gnt, bus_out, bus_valid, bus_owner, conflict, conflict_sticky
  );

  // The arbiter itself.
  modport slave (
    input  src_req, src_data, hold, clear_sticky,
    output src_gnt, bus_out, bus_valid, bus_owner, conflict, conflict_sticky
  );

endinterface : bus_arb_mux_if

// File: rtl/rr_arbiter.sv
// Purely combinational arbiter: fixed lowest-index priority, or a round-robin
// search starting at ptr and wrapping from N-1 back to 0.
module rr_arbiter
  import bus_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  arb_mode_e     mode,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] winner
);

  int   base;
  int   idx;
  logic found;

  // NOTE: every output gets a default before the search so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    base   = (mode == ARB_RR) ? int'(ptr) : 0;
    for (int off = 0; off < N; off++) begin
      idx = base + off;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        winner   = IW'(idx);
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/bus_arb_mux.sv
// Registered datapath bus: arbitrates N_SRC sources, latches the winner's data
// one cycle later, and tracks request conflicts.
module bus_arb_mux
  import bus_pkg::*;
#(
  parameter int WIDTH     = BUS_WIDTH,
  parameter int N_SRC     = 4,
  parameter int RR_MODE   = 0,
  parameter int IDLE_HOLD = 1
) (
  input logic         clk,
  input logic         reset,
  bus_arb_mux_if.slave bus
);

  localparam int        OW   = $clog2(N_SRC);
  localparam arb_mode_e MODE = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

  logic [N_SRC-1:0] req_eff;
  logic [N_SRC-1:0] gnt;
  logic [OW-1:0]    winner;
  logic             grant_any;
  logic             multi_req;
  logic [OW-1:0]    ptr_next;

  logic [WIDTH-1:0] bus_out_q;
  logic             bus_valid_q;
  logic [OW-1:0]    bus_owner_q;
  logic             conflict_q;
  logic             sticky_q;
  logic [OW-1:0]    ptr_q;

  // Stall and reset both suppress the grant, so no source sees a gate enable.
  assign req_eff   = (reset || bus.hold) ? '0 : bus.src_req;
  assign grant_any = |gnt;
  assign multi_req = $countones(bus.src_req) > 1;
  assign ptr_next  = (winner == OW'(N_SRC - 1)) ? '0 : winner + OW'(1);

  rr_arbiter #(.N(N_SRC)) u_arb (
    .req    (req_eff),
    .ptr    (ptr_q),
    .mode   (MODE),
    .gnt    (gnt),
    .winner (winner)
  );

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_out_q   <= '0;
      bus_valid_q <= 1'b0;
      bus_owner_q <= '0;
      conflict_q  <= 1'b0;
      sticky_q    <= 1'b0;
      ptr_q       <= '0;
    end else begin
      if (!bus.hold) begin
        conflict_q <= multi_req;
        if (grant_any) begin
          bus_out_q   <= bus.src_data[int'(winner)*WIDTH +: WIDTH];
          bus_valid_q <= 1'b1;
          bus_owner_q <= winner;
          if (MODE == ARB_RR) ptr_q <= ptr_next;
        end else begin
          bus_valid_q <= 1'b0;
          if (IDLE_HOLD == 0) bus_out_q <= '0;
        end
      end
      // A fresh conflict beats a simultaneous clear; clear still works in hold.
      if (!bus.hold && multi_req) sticky_q <= 1'b1;
      else if (bus.clear_sticky)  sticky_q <= 1'b0;
    end
  end

  assign bus.src_gnt         = gnt;
  assign bus.bus_out         = bus_out_q;
  assign bus.bus_valid       = bus_valid_q;
  assign bus.bus_owner       = bus_owner_q;
  assign bus.conflict        = conflict_q;
  assign bus.conflict_sticky = sticky_q;

endmodule : bus_arb_mux

// File: tb/tb_bus_arb_mux.sv
// Drives a fixed-priority/idle-hold and a round-robin/idle-clear instance with
// identical stimulus and scores both against a spec-level model.
module tb_bus_arb_mux;
  import bus_pkg::*;

  localparam int W = 16;
  localparam int N = 4;

  typedef struct {
    logic [W-1:0] bus_out;
    logic         valid;
    int           owner;
    logic         conflict;
    logic         sticky;
    int           ptr;
  } st_t;

  typedef struct {
    logic [N-1:0] gnt_f;
    logic [N-1:0] gnt_r;
    st_t          st_f;
    st_t          st_r;
  } rec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  rec_t exp_q[$];
  st_t  mf, mr;

  always #5 clk = ~clk;

  bus_arb_mux_if #(.WIDTH(W), .N_SRC(N)) if_f ();
  bus_arb_mux_if #(.WIDTH(W), .N_SRC(N)) if_r ();

  bus_arb_mux #(.WIDTH(W), .N_SRC(N), .RR_MODE(0), .IDLE_HOLD(1)) dut_fix (
    .clk(clk), .reset(reset), .bus(if_f));
  bus_arb_mux #(.WIDTH(W), .N_SRC(N), .RR_MODE(1), .IDLE_HOLD(0)) dut_rr (
    .clk(clk), .reset(reset), .bus(if_r));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic st_t reset_state();
    st_t s;
    s.bus_out = '0; s.valid = 1'b0; s.owner = 0;
    s.conflict = 1'b0; s.sticky = 1'b0; s.ptr = 0;
    return s;
  endfunction

  // Reference behaviour: grant for the current cycle and the state after the edge.
  function automatic st_t step(input st_t s, input logic rst, input logic h,
                               input logic clr, input logic [N-1:0] req,
                               input logic [N*W-1:0] data, input bit rr,
                               input bit idle_hold, output logic [N-1:0] gnt);
    st_t n;
    int  win;
    int  cnt;
    int  c;
    n   = s;
    win = -1;
    cnt = 0;
    gnt = '0;
    if (rst) return reset_state();
    if (h) begin
      if (clr) n.sticky = 1'b0;
      return n;
    end
    for (int i = 0; i < N; i++) cnt += int'(req[i]);
    for (int k = 0; k < N; k++) begin
      c = rr ? (s.ptr + k) % N : k;
      if (win < 0 && req[c]) win = c;
    end
    n.conflict = (cnt > 1);
    if (cnt > 1) n.sticky = 1'b1;
    else if (clr) n.sticky = 1'b0;
    if (win >= 0) begin
      gnt[win]  = 1'b1;
      n.bus_out = data[win*W +: W];
      n.valid   = 1'b1;
      n.owner   = win;
      if (rr) n.ptr = (win + 1) % N;
    end else begin
      n.valid = 1'b0;
      if (!idle_hold) n.bus_out = '0;
    end
    return n;
  endfunction

  task automatic drive(input logic rst, input logic [N-1:0] req,
                       input logic [N*W-1:0] data, input logic h, input logic clr);
    rec_t r;
    reset = rst;
    if_f.src_req = req; if_f.src_data = data; if_f.hold = h; if_f.clear_sticky = clr;
    if_r.src_req = req; if_r.src_data = data; if_r.hold = h; if_r.clear_sticky = clr;
    r.st_f = mf;
    r.st_r = mr;
    mf = step(mf, rst, h, clr, req, data, 1'b0, 1'b1, r.gnt_f);
    mr = step(mr, rst, h, clr, req, data, 1'b1, 1'b0, r.gnt_r);
    exp_q.push_back(r);
    @(posedge clk);
    #1;
  endtask

  // Monitor: mid-cycle, grants reflect this cycle's inputs and the registers
  // reflect the previous edge.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        check("fix.src_gnt",  64'(if_f.src_gnt),         64'(r.gnt_f));
        check("fix.bus_out",  64'(if_f.bus_out),         64'(r.st_f.bus_out));
        check("fix.valid",    64'(if_f.bus_valid),       64'(r.st_f.valid));
        check("fix.owner",    64'(if_f.bus_owner),       64'(r.st_f.owner));
        check("fix.conflict", 64'(if_f.conflict),        64'(r.st_f.conflict));
        check("fix.sticky",   64'(if_f.conflict_sticky), 64'(r.st_f.sticky));
        check("rr.src_gnt",   64'(if_r.src_gnt),         64'(r.gnt_r));
        check("rr.bus_out",   64'(if_r.bus_out),         64'(r.st_r.bus_out));
        check("rr.valid",     64'(if_r.bus_valid),       64'(r.st_r.valid));
        check("rr.owner",     64'(if_r.bus_owner),       64'(r.st_r.owner));
        check("rr.conflict",  64'(if_r.conflict),        64'(r.st_r.conflict));
        check("rr.sticky",    64'(if_r.conflict_sticky), 64'(r.st_r.sticky));
      end
    end
  end

  initial begin
    logic [N*W-1:0] d;
    logic [N-1:0]   rq;
    reset = 1'b1;
    if_f.src_req = '0; if_f.src_data = '0; if_f.hold = 1'b0; if_f.clear_sticky = 1'b0;
    if_r.src_req = '0; if_r.src_data = '0; if_r.hold = 1'b0; if_r.clear_sticky = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mf = reset_state();
    mr = reset_state();

    // Idle after reset.
    repeat (3) drive(1'b0, 4'b0000, '0, 1'b0, 1'b0);

    // Two requesters: MDR beats ALU under fixed priority, conflict flagged.
    d = '0;
    d[SRC_MDR*W +: W] = 16'h3001;
    d[SRC_ALU*W +: W] = 16'hBEEF;
    drive(1'b0, 4'b0110, d, 1'b0, 1'b0);
    drive(1'b0, 4'b0000, d, 1'b0, 1'b0);

    // Round-robin rotation from pointer 0 with wrap.
    drive(1'b1, 4'b0000, '0, 1'b0, 1'b1);
    d = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    repeat (5) drive(1'b0, 4'b1111, d, 1'b0, 1'b0);

    // Stall right after a load of 16'h1234, then resume.
    d = '0;
    d[SRC_PC*W +: W] = 16'h1234;
    drive(1'b0, 4'b0001, d, 1'b0, 1'b0);
    drive(1'b0, 4'b0001, d, 1'b1, 1'b0);
    drive(1'b0, 4'b0001, d, 1'b1, 1'b0);
    drive(1'b0, 4'b0001, d, 1'b0, 1'b0);

    // Sticky: set beats clear, then a lone request lets clear take effect.
    drive(1'b0, 4'b0011, d, 1'b0, 1'b1);
    drive(1'b0, 4'b0001, d, 1'b0, 1'b1);
    drive(1'b0, 4'b0000, d, 1'b0, 1'b0);

    // Mid-stream reset with pointer at 2.
    drive(1'b1, 4'b0000, '0, 1'b0, 1'b0);
    d = {16'hD003, 16'hC002, 16'hB001, 16'hA000};
    drive(1'b0, 4'b0010, d, 1'b0, 1'b0);
    drive(1'b1, 4'b1000, d, 1'b0, 1'b0);
    drive(1'b0, 4'b1001, d, 1'b0, 1'b0);
    drive(1'b0, 4'b0000, d, 1'b0, 1'b0);

    // Random traffic with occasional stall, clear and reset.
    for (int i = 0; i < 400; i++) begin
      d  = {$urandom, $urandom};
      rq = 4'($urandom);
      drive($urandom_range(63) == 0, rq, d,
            $urandom_range(7) == 0, $urandom_range(5) == 0);
    end
    drive(1'b0, 4'b0000, '0, 1'b0, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bus_arb_mux

// File: doc/bus_arb_mux.md
Name: bus_arb_mux

Overview:
Parametrised, registered successor to the datapath source muxes. Arbitrates N_SRC request/grant sources (PC, MDR, ALU, MARMUX, ...) onto the shared datapath bus. Supports fixed-priority or round-robin arbitration, a stall hold, conflict detection, and a registered bus with one-cycle latency. It sits between the datapath source registers and every bus consumer (MAR, MDR, IR, PC, register file).

Parameters:
WIDTH, 16, bus data width in bits (≥1)
N_SRC, 4, number of bus sources (2..16)
RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
IDLE_HOLD, 1, 1 = bus_out keeps its last value when no grant; 0 = bus_out drives 0 when no grant

Ports:
Clk  in  1  system clock, all state updates on rising edge
Reset  in  1  synchronous, active-high reset
src_req  in  N_SRC  per-source bus request (gate enable)
src_data  in  N_SRC*WIDTH  packed source data; source i occupies bits [i*WIDTH +: WIDTH]
hold  in  1  stall: no grant issued, all state frozen
clear_sticky  in  1  clears conflict_sticky
src_gnt  out  N_SRC  one-hot combinational grant for the current cycle
bus_out  out  WIDTH  registered bus value
bus_valid  out  1  registered; 1 when bus_out was loaded from a grant in the previous cycle
bus_owner  out  clog2(N_SRC)  registered index of the source that produced bus_out
conflict  out  1  registered; 1 when more than one request was present in the last arbitration cycle
conflict_sticky  out  1  set on any conflict, held until cleared

Behaviour:
- Reset (synchronous, active-high) sets bus_out=0, bus_valid=0, bus_owner=0, conflict=0, conflict_sticky=0, and the round-robin pointer to 0. While Reset is high, src_gnt=0.
- Grant (combinational): src_gnt=0 if hold=1 or src_req=0. Otherwise exactly one bit is set.
  - RR_MODE=0: the lowest-index requester wins.
  - RR_MODE=1: the first requester at or after the pointer wins, searching upward and wrapping from N_SRC-1 to 0.
- Latency: data granted in cycle t appears on bus_out in cycle t+1. bus_valid=1 and bus_owner=winner in that same cycle.
- No grant with hold=0: bus_valid←0, bus_owner holds its value. bus_out holds if IDLE_HOLD=1, or is cleared to 0 if IDLE_HOLD=0.
- hold=1: bus_out, bus_valid, bus_owner, conflict and the pointer all keep their values. Requests are ignored and no conflict is evaluated.
- Round-robin pointer: on a grant it becomes winner+1 modulo N_SRC (so N_SRC-1 wraps to 0). It is unchanged when there is no grant. In RR_MODE=0 it is not used.
- conflict: updated only when hold=0. It is registered as (popcount(src_req) > 1).
- conflict_sticky: if a new conflict and clear_sticky occur in the same cycle, set wins. clear_sticky is honoured during hold.
- Width rule: bus_out is a straight copy of the WIDTH-bit slice, with no extension or truncation.
- A mid-operation Reset overrides hold and any in-flight grant. The cycle after Reset deasserts arbitrates normally with the pointer at 0.

Decomposition:
- Shared package bus_pkg holds:
  - default BUS_WIDTH=16;
  - source index constants SRC_PC=0, SRC_MDR=1, SRC_ALU=2, SRC_MARMUX=3;
  - an arb_mode_e enum (ARB_FIXED, ARB_RR).
- One sub-module, rr_arbiter (parameter N, inputs req/ptr/mode, output one-hot gnt plus winner index), is purely combinational. bus_arb_mux instantiates it and owns all registers.

Test Plan:
- Reset, then src_req=4'b0000 for 3 cycles -> bus_out=16'h0000, bus_valid=0, src_gnt=0 throughout.
- RR_MODE=0: src_req=4'b0110, src_data[1]=16'h3001, src_data[2]=16'hBEEF -> src_gnt=4'b0010; next cycle bus_out=16'h3001, bus_owner=1, conflict=1, conflict_sticky=1.
- RR_MODE=1: src_req=4'b1111 held for 5 cycles -> grants 0,1,2,3,0 in order; bus_owner lags by one cycle; pointer wraps 3→0.
- hold=1 in the cycle after bus_out=16'h1234 while src_req=4'b0001 -> src_gnt=0; bus_out stays 16'h1234, bus_valid and conflict unchanged, pointer unchanged. After hold drops, the grant resumes at the same pointer.
- conflict_sticky=1, then src_req=4'b0011 with clear_sticky=1 in the same cycle -> conflict_sticky stays 1. A following cycle with src_req=4'b0001 and clear_sticky=1 -> conflict_sticky=0.
- Reset asserted for one cycle mid-stream during src_req=4'b1000 with the pointer at 2 -> the next cycle shows bus_out=0, bus_valid=0, pointer=0. The next grant from src_req=4'b1001 goes to source 0 (RR_MODE=1).
